// File: rtl/servant_sleep_ctrl_if.sv
// Sleep-controller signal bundle between the servant core/SoC (master) and the controller (slave).
interface servant_sleep_ctrl_if #(
  parameter int unsigned NIRQ  = 4,
  parameter int unsigned CNT_W = 16
);
  logic             i_sleep_req;
  logic             i_bus_idle;
  logic [NIRQ-1:0]  i_irq;
  logic [NIRQ-1:0]  i_irq_mask;
  logic [NIRQ-1:0]  i_irq_ack;
  logic             o_clk_en;
  logic             o_sleeping;
  logic             o_wakeup;
  logic [NIRQ-1:0]  o_pending;
  logic [CNT_W-1:0] o_sleep_cycles;

  modport master (
    output i_sleep_req, i_bus_idle, i_irq, i_irq_mask, i_irq_ack,
    input  o_clk_en, o_sleeping, o_wakeup, o_pending, o_sleep_cycles
  );

  modport slave (
    input  i_sleep_req, i_bus_idle, i_irq, i_irq_mask, i_irq_ack,
    output o_clk_en, o_sleeping, o_wakeup, o_pending, o_sleep_cycles
  );
endinterface

// File: rtl/servant_sleep_ctrl.sv
// Multi-channel sleep/wake controller: drains the bus, gates the core clock via a registered
// ICG enable, wakes on masked pending interrupts after a programmable delay, counts sleep cycles.
module servant_sleep_ctrl #(
  parameter int unsigned NIRQ     = 4,
  parameter int unsigned WAKE_DLY = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic               i_clk,
  input logic               i_rst_n,
  servant_sleep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StDrain, StSleep, StWake} state_e;

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [NIRQ-1:0]  pend_q, pend_d;
  logic             clk_en_q, clk_en_d;
  logic             sleeping_q, sleeping_d;
  logic             wakeup_q, wakeup_d;
  logic             any_pend;

  assign any_pend = |pend_q;

  // A new unmasked request wins over a simultaneous ack.
  assign pend_d = (pend_q & ~bus.i_irq_ack) | (bus.i_irq & bus.i_irq_mask);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      StRun: begin
        if (bus.i_sleep_req && !any_pend) begin
          state_d = StDrain;
          cyc_d   = '0;
        end
      end
      StDrain: begin
        if (any_pend) begin
          state_d = StRun;
        end else if (bus.i_bus_idle) begin
          state_d = StSleep;
        end
      end
      StSleep: begin
        if (cyc_q != '1) begin
          cyc_d = cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (any_pend) begin
          state_d = StWake;
          wcnt_d  = 8'(WAKE_DLY);
        end
      end
      StWake: begin
        if (wcnt_q == 8'd0) begin
          state_d = StRun;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      default: state_d = StRun;
    endcase

    // Outputs are computed from the next state so they are registered alongside it.
    clk_en_d   = (state_d == StRun) || (state_d == StDrain);
    sleeping_d = !clk_en_d;
    wakeup_d   = ((state_q == StDrain) || (state_q == StWake)) && (state_d == StRun);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StRun;
      wcnt_q     <= 8'd0;
      cyc_q      <= '0;
      pend_q     <= '0;
      clk_en_q   <= 1'b1;
      sleeping_q <= 1'b0;
      wakeup_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      cyc_q      <= cyc_d;
      pend_q     <= pend_d;
      clk_en_q   <= clk_en_d;
      sleeping_q <= sleeping_d;
      wakeup_q   <= wakeup_d;
    end
  end

  assign bus.o_clk_en       = clk_en_q;
  assign bus.o_sleeping     = sleeping_q;
  assign bus.o_wakeup       = wakeup_q;
  assign bus.o_pending      = pend_q;
  assign bus.o_sleep_cycles = cyc_q;

endmodule
